// File: rtl/wb_regfile.sv
// Purpose: MEM/WB writeback mux, 32-entry GPR file with two bypassed read ports, commit counter.
// Latency: reads and wb_data_o are combinational; a commit becomes stored state after 1 clk edge.
// Backpressure: none; every edge with regwrite_i and a nonzero destination commits unconditionally.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] memdata_i,
    input  logic [DATA_W-1:0] aluresult_i,
    input  logic [ADDR_W-1:0] regdest_i,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [31:0]       wb_count_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [31:0]       wb_count_q;
    logic              commit;

    // Writeback value selection and commit qualification. Register 0 never commits,
    // and an asserted reset kills any write that is pending in the current cycle.
    always_comb begin
        wb_data_o = memtoreg_i ? memdata_i : aluresult_i;
        commit    = regwrite_i && (regdest_i != '0) && !reset;
    end

    // Register file storage. Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[regdest_i] <= wb_data_o;
        end
    end

    // Commit counter; wraps naturally modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_count_q <= '0;
        end else if (commit) begin
            wb_count_q <= wb_count_q + 32'd1;
        end
    end

    assign wb_count_o = wb_count_q;

    // One read port: zero register first, then same-cycle forwarding of the committing value,
    // then stored state. Reset forces zero so no stale or forwarded data leaks out.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (reset || addr == '0) begin
            val = '0;
        end else if (BYPASS && commit && addr == regdest_i) begin
            val = wb_data_o;
        end else begin
            val = regs[addr];
        end
        return val;
    endfunction

    // Both read ports share the same lookup, so identical addresses return identical data.
    always_comb begin
        rs_data_o = read_port(rs_addr_i);
        rt_data_o = read_port(rt_addr_i);
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memdata_i, aluresult_i;
    logic [4:0]  regdest_i, rs_addr_i, rt_addr_i;
    logic        regwrite_i, memtoreg_i;

    logic [31:0] rs_data_o, rt_data_o, wb_data_o, wb_count_o;
    logic [31:0] nb_rs_data, nb_rt_data, nb_wb_data, nb_wb_count;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .memdata_i(memdata_i), .aluresult_i(aluresult_i), .regdest_i(regdest_i),
        .regwrite_i(regwrite_i), .memtoreg_i(memtoreg_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
        .wb_data_o(wb_data_o), .wb_count_o(wb_count_o)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset),
        .memdata_i(memdata_i), .aluresult_i(aluresult_i), .regdest_i(regdest_i),
        .regwrite_i(regwrite_i), .memtoreg_i(memtoreg_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .rs_data_o(nb_rs_data), .rt_data_o(nb_rt_data),
        .wb_data_o(nb_wb_data), .wb_count_o(nb_wb_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; memdata_i = '0; aluresult_i = '0; regdest_i = '0;
        regwrite_i = 1'b0; memtoreg_i = 1'b0; rs_addr_i = '0; rt_addr_i = '0;

        // Reset state
        #2;
        rs_addr_i = 5'd5; rt_addr_i = 5'd9;
        #1;
        chk("rst_rs", rs_data_o, 32'h0);
        chk("rst_rt", rt_data_o, 32'h0);
        chk("rst_cnt", wb_count_o, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Write $5 = 0x1234, visible after one edge
        regwrite_i = 1'b1; regdest_i = 5'd5; aluresult_i = 32'h1234;
        tick();
        regwrite_i = 1'b0;
        #1;
        chk("wr5_rs", rs_data_o, 32'h1234);
        chk("wr5_cnt", wb_count_o, 32'd1);

        // Reset mid-cycle: immediate clear, pending write to $6 lost, wb_data_o still combinational
        rs_addr_i = 5'd5;
        reset = 1'b1;
        regwrite_i = 1'b1; regdest_i = 5'd6; aluresult_i = 32'h77;
        #1;
        chk("rstmid_rs", rs_data_o, 32'h0);
        chk("rstmid_cnt", wb_count_o, 32'h0);
        chk("rstmid_wbdat", wb_data_o, 32'h77);
        rt_addr_i = 5'd6;
        #1;
        chk("rstmid_byp", rt_data_o, 32'h0);
        tick();
        reset = 1'b0; regwrite_i = 1'b0;
        #1;
        chk("postrst_r5", rs_data_o, 32'h0);
        chk("postrst_r6", rt_data_o, 32'h0);
        chk("postrst_cnt", wb_count_o, 32'h0);

        // Mux, ALU path
        regwrite_i = 1'b1; regdest_i = 5'd8; memtoreg_i = 1'b0;
        aluresult_i = 32'hDEADBEEF; memdata_i = 32'h11111111;
        rs_addr_i = 5'd0; rt_addr_i = 5'd8;
        #1;
        chk("mux_alu", wb_data_o, 32'hDEADBEEF);
        chk("nb_pre_r8", nb_rt_data, 32'h0);
        tick();
        chk("r8_alu", rt_data_o, 32'hDEADBEEF);
        chk("nb_r8_alu", nb_rt_data, 32'hDEADBEEF);
        chk("cnt_1", wb_count_o, 32'd1);

        // Mux, memory path
        memtoreg_i = 1'b1;
        #1;
        chk("mux_mem", wb_data_o, 32'h11111111);
        tick();
        regwrite_i = 1'b0;
        #1;
        chk("r8_mem", rt_data_o, 32'h11111111);
        chk("cnt_2", wb_count_o, 32'd2);

        // Zero register: discarded, not counted, never bypassed
        regwrite_i = 1'b1; regdest_i = 5'd0; memtoreg_i = 1'b0; aluresult_i = 32'hFFFFFFFF;
        rs_addr_i = 5'd0;
        #1;
        chk("r0_pre", rs_data_o, 32'h0);
        tick();
        regwrite_i = 1'b0;
        #1;
        chk("r0_post", rs_data_o, 32'h0);
        chk("r0_cnt", wb_count_o, 32'd2);

        // Bypass: $3 = 0xA, then overwrite with 0xB while reading it on both ports
        regwrite_i = 1'b1; regdest_i = 5'd3; aluresult_i = 32'hA;
        tick();
        aluresult_i = 32'hB; rs_addr_i = 5'd3; rt_addr_i = 5'd3;
        #1;
        chk("byp_rs", rs_data_o, 32'hB);
        chk("byp_rt", rt_data_o, 32'hB);
        chk("nobyp_rs", nb_rs_data, 32'hA);
        chk("nobyp_rt", nb_rt_data, 32'hA);
        tick();
        regwrite_i = 1'b0;
        #1;
        chk("byp_post_rs", rs_data_o, 32'hB);
        chk("nobyp_post_rt", nb_rt_data, 32'hB);
        chk("byp_cnt", wb_count_o, 32'd4);

        // Bubble: regwrite low, nothing changes, no forwarding
        regwrite_i = 1'b0; regdest_i = 5'd7; aluresult_i = 32'h55; rs_addr_i = 5'd7;
        #1;
        chk("bub_nobyp", rs_data_o, 32'h0);
        tick(); tick(); tick();
        chk("bub_r7", rs_data_o, 32'h0);
        chk("bub_cnt", wb_count_o, 32'd4);

        // Counter wrap from a preloaded value
        @(negedge clk);
        force dut.wb_count_q = 32'hFFFFFFFE;
        #1;
        release dut.wb_count_q;
        #1;
        chk("wrap_pre", wb_count_o, 32'hFFFFFFFE);
        regwrite_i = 1'b1; regdest_i = 5'd1; aluresult_i = 32'h1; rs_addr_i = 5'd1;
        tick();
        chk("wrap_ff", wb_count_o, 32'hFFFFFFFF);
        tick();
        regwrite_i = 1'b0;
        #1;
        chk("wrap_zero", wb_count_o, 32'h0);
        chk("wrap_r1", rs_data_o, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
